// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared widths, index/data types and helpers for regfile writeback.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_WIDTH_DEF = 64;
    localparam int NUM_REGS_DEF  = 32;
    localparam int NUM_REQ_DEF   = 2;
    localparam int AW_DEF        = $clog2(NUM_REGS_DEF);
    localparam int ZERO_REG      = NUM_REGS_DEF - 1;

    typedef logic [AW_DEF-1:0]        reg_idx_t;
    typedef logic [REG_WIDTH_DEF-1:0] reg_data_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Purpose  : Writeback requester bundle (valid/ready, index, data per source).
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int REG_WIDTH = REG_WIDTH_DEF
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*AW-1:0]        req_reg;
    logic [NUM_REQ*REG_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin single-grant arbiter; pointer moves past each winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               enable,
    input  wire logic [NUM_REQ-1:0] req,
    output logic      [NUM_REQ-1:0] grant,
    output logic      [IW-1:0]      grant_idx,
    output logic                    grant_valid
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Reset is folded into the grant so ready stays low while it is held.
    always_comb begin
        logic [IW-1:0] cand;
        cand        = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (reset && enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IW'((int'(ptr_q) + k) % NUM_REQ);
                if (!grant_valid && req[cand]) begin
                    grant_valid = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the regfile write port among writeback sources, drops X31.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int REG_WIDTH = REG_WIDTH_DEF,
    parameter  int NUM_REGS  = NUM_REGS_DEF,
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 enable,
    regfile_wb_arbiter_if.slave       wb,
    input  wire logic [AW-1:0]        ReadRegister1,
    input  wire logic [AW-1:0]        ReadRegister2,
    output logic                      RegWrite,
    output logic      [AW-1:0]        WriteRegister,
    output logic      [REG_WIDTH-1:0] WriteData,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic      [7:0]           drop_count
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam logic [AW-1:0] ZERO_IDX = AW'(NUM_REGS - 1);

    logic [IW-1:0]        grant_idx;
    logic                 grant_valid;
    logic [AW-1:0]        sel_reg;
    logic [REG_WIDTH-1:0] sel_data;

    logic                 regwrite_q, regwrite_d;
    logic [AW-1:0]        wreg_q,     wreg_d;
    logic [REG_WIDTH-1:0] wdata_q,    wdata_d;
    logic [7:0]           drop_q,     drop_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (wb.req_valid),
        .grant       (wb.req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_reg  = wb.req_reg[int'(grant_idx)*AW +: AW];
    assign sel_data = wb.req_data[int'(grant_idx)*REG_WIDTH +: REG_WIDTH];

    // X31 writes still complete the handshake but never reach the regfile.
    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        drop_d     = drop_q;
        if (grant_valid) begin
            wreg_d     = sel_reg;
            wdata_d    = sel_data;
            regwrite_d = (sel_reg != ZERO_IDX);
            if (sel_reg == ZERO_IDX) begin
                drop_d = sat_inc8(drop_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            drop_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            drop_q     <= drop_d;
        end
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign drop_count    = drop_q;

    assign hazard1 = regwrite_q && (wreg_q == ReadRegister1);
    assign hazard2 = regwrite_q && (wreg_q == ReadRegister2);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic     clk;
    logic     reset;
    logic     enable;
    reg_idx_t rd1, rd2;
    logic     RegWrite;
    reg_idx_t WriteRegister;
    reg_data_t WriteData;
    logic     hazard1, hazard2;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_data_t rf [NUM_REGS_DEF];

    regfile_wb_arbiter_if #(.NUM_REQ(2), .AW(AW_DEF), .REG_WIDTH(REG_WIDTH_DEF)) wb ();

    regfile_wb_arbiter #(
        .REG_WIDTH (REG_WIDTH_DEF),
        .NUM_REGS  (NUM_REGS_DEF),
        .NUM_REQ   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .wb            (wb.slave),
        .ReadRegister1 (rd1),
        .ReadRegister2 (rd2),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model fed from the arbiter's write port.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS_DEF; i++) rf[i] <= '0;
        end else if (RegWrite) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input reg_idx_t r, input reg_data_t d);
        wb.req_valid[i]                       = v;
        wb.req_reg[i*AW_DEF +: AW_DEF]        = r;
        wb.req_data[i*REG_WIDTH_DEF +: REG_WIDTH_DEF] = d;
    endtask

    initial begin : stim
        int        cnt0, cnt1, seen;
        logic [1:0] g;
        reg_idx_t  exp_order [8];
        exp_order = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4, 5'd13};

        reset  = 1'b1;
        enable = 1'b0;
        rd1    = '0;
        rd2    = '0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        #3 reset = 1'b0;

        // Reset state; requests present while reset is held must not be granted.
        @(negedge clk);
        enable = 1'b1;
        set_req(0, 1'b1, 5'd3, 64'h33);
        set_req(1, 1'b1, 5'd4, 64'h44);
        #1;
        check("rst_ready", {62'd0, wb.req_ready}, 64'd0);
        check("rst_we",    {63'd0, RegWrite},     64'd0);
        check("rst_wreg",  {59'd0, WriteRegister}, 64'd0);
        check("rst_wdata", WriteData,             64'd0);
        check("rst_drop",  {56'd0, drop_count},   64'd0);
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);

        // Single writer: requester 0 writes X5.
        @(negedge clk);
        rd1 = 5'd5;
        rd2 = 5'd0;
        set_req(0, 1'b1, 5'd5, 64'h1234);
        #1 check("sw_ready", {62'd0, wb.req_ready}, 64'd1);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0);
        check("sw_we",    {63'd0, RegWrite},      64'd1);
        check("sw_wreg",  {59'd0, WriteRegister}, 64'd5);
        check("sw_wdata", WriteData,              64'h1234);
        check("sw_haz1",  {63'd0, hazard1},       64'd1);
        check("sw_haz2",  {63'd0, hazard2},       64'd0);
        #1 check("sw_ready_off", {62'd0, wb.req_ready}, 64'd0);
        @(negedge clk);
        check("sw_rf5",   rf[5],                  64'h1234);
        check("sw_we_off", {63'd0, RegWrite},     64'd0);

        // X31 drop: requester 1 writes X31 three times back to back.
        rd1 = 5'd31;
        rd2 = 5'd31;
        set_req(1, 1'b1, 5'd31, 64'hA0);
        for (int k = 0; k < 3; k++) begin
            #1 check("x31_ready", {62'd0, wb.req_ready}, 64'd2);
            @(negedge clk);
            check("x31_we",   {63'd0, RegWrite}, 64'd0);
            check("x31_haz1", {63'd0, hazard1},  64'd0);
            check("x31_haz2", {63'd0, hazard2},  64'd0);
        end
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        check("x31_drop", {56'd0, drop_count}, 64'd3);
        check("x31_rf",   rf[31],              64'd0);

        // Contention: both requesters held valid, served in strict rotation.
        cnt0 = 0;
        cnt1 = 0;
        seen = 0;
        set_req(0, 1'b1, 5'd1,  64'h101);
        set_req(1, 1'b1, 5'd10, 64'h10A);
        for (int c = 0; c < 12; c++) begin
            #1 g = wb.req_ready;
            check("cont_onehot", 64'($countones(g)), 64'd1);
            if (g[0]) cnt0++;
            if (g[1]) cnt1++;
            @(negedge clk);
            if (g != 2'b00 && seen < 8) begin
                check("cont_we",    {63'd0, RegWrite},      64'd1);
                check("cont_wreg",  {59'd0, WriteRegister}, {59'd0, exp_order[seen]});
                check("cont_wdata", WriteData,              64'h100 + {59'd0, exp_order[seen]});
                seen++;
            end
            set_req(0, cnt0 < 4, 5'(1 + cnt0),  64'h100 + 64'(1 + cnt0));
            set_req(1, cnt1 < 4, 5'(10 + cnt1), 64'h100 + 64'(10 + cnt1));
            if (wb.req_valid == 2'b00) break;
        end
        check("cont_total", 64'(seen), 64'd8);

        // Enable gating, then resume at the requester after the last grant.
        enable = 1'b0;
        set_req(0, 1'b1, 5'd20, 64'h20);
        set_req(1, 1'b1, 5'd21, 64'h21);
        for (int k = 0; k < 4; k++) begin
            #1 check("en_ready", {62'd0, wb.req_ready}, 64'd0);
            @(negedge clk);
            check("en_we", {63'd0, RegWrite}, 64'd0);
        end
        enable = 1'b1;
        #1 check("en_resume", {62'd0, wb.req_ready}, 64'd1);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        check("en_wreg", {59'd0, WriteRegister}, 64'd20);

        // Saturation of the drop counter.
        set_req(1, 1'b1, 5'd31, 64'hA0);
        for (int k = 0; k < 300; k++) @(negedge clk);
        check("sat_drop", {56'd0, drop_count}, 64'd255);
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        check("sat_hold", {56'd0, drop_count}, 64'd255);
        check("sat_we",   {63'd0, RegWrite},   64'd0);

        // Asynchronous reset with a registered write pending.
        set_req(0, 1'b1, 5'd6, 64'h66);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0);
        check("mr_we_pre", {63'd0, RegWrite}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mr_we",    {63'd0, RegWrite},      64'd0);
        check("mr_wreg",  {59'd0, WriteRegister}, 64'd0);
        check("mr_wdata", WriteData,              64'd0);
        check("mr_drop",  {56'd0, drop_count},    64'd0);
        set_req(0, 1'b1, 5'd7, 64'h77);
        set_req(1, 1'b1, 5'd8, 64'h88);
        #1 check("mr_ready", {62'd0, wb.req_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
